// File: rtl/rx_len_count_ctrl.sv
// -----------------------------------------------------------------------------
// rx_len_count_ctrl
//
// Per-frame sequencer for the receive 64-bit data-word counters. It decodes the
// captured length/type field, computes the word counts for the data field, and
// enables either the untagged or the tagged data counter for the duration of
// the data field. The end_* strobes and eof frame the payload.
//
// Ports
//   rxclk             in   receive clock
//   reset             in   asynchronous, active-low reset
//   sof               in   start-of-frame word seen (1-cycle pulse)
//   len_valid         in   len_type / vlan_detect valid (1-cycle pulse)
//   len_type          in   16-bit length/type field
//   vlan_detect       in   frame carries an 802.1Q tag
//   eof               in   terminate seen (1-cycle pulse)
//   abort             in   drop current frame (highest priority)
//   end_data_cnt      in   data-field word count reached
//   end_small_cnt     in   true data of a small frame reached (sampled only)
//   start_data_cnt    out  enable untagged data counter
//   start_tagged_cnt  out  enable tagged data counter
//   small_frame       out  data field below minimum (padded)
//   tagged_frame      out  frame is VLAN tagged
//   integer_cnt       out  64-bit words in the data field
//   small_integer_cnt out  64-bit words of real (unpadded) data
//   data_done         out  data field complete (1-cycle pulse)
//   len_err           out  length/framing error (1-cycle pulse)
//   busy              out  sequencer not idle
//   dbg_state         out  current FSM state (debug)
//   small_data_seen   out  end_small_cnt observed during a small frame (debug)
//
// Handshake: sof, len_valid, eof, end_data_cnt and end_small_cnt are
// single-cycle qualifiers sampled on the rising edge of rxclk; there is no
// back-pressure. data_done and len_err are single-cycle registered pulses.
// start_data_cnt / start_tagged_cnt are level enables; their falling edge is
// the counter reload, and at most one of them is ever high.
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module rx_len_count_ctrl #(
  parameter int WIDTH        = 13,
  parameter int MAX_LEN      = 1500,
  parameter int MIN_DATA     = 46,
  parameter int MIN_DATA_TAG = 42,
  parameter int TYPE_WORDS   = 188
) (
  input  logic             rxclk,
  input  logic             reset,
  input  logic             sof,
  input  logic             len_valid,
  input  logic [15:0]      len_type,
  input  logic             vlan_detect,
  input  logic             eof,
  input  logic             abort,
  input  logic             end_data_cnt,
  input  logic             end_small_cnt,
  output logic             start_data_cnt,
  output logic             start_tagged_cnt,
  output logic             small_frame,
  output logic             tagged_frame,
  output logic [WIDTH-1:0] integer_cnt,
  output logic [WIDTH-1:0] small_integer_cnt,
  output logic             data_done,
  output logic             len_err,
  output logic             busy,
  output logic [1:0]       dbg_state,
  output logic             small_data_seen
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_LEN = 2'd1,
    COUNT    = 2'd2,
    TAIL     = 2'd3
  } state_t;

  localparam logic [15:0] TYPE_MIN = 16'h0600;

  // ---------------------------------------------------------------------------
  // Registered state and outputs
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic             start_data_q, start_data_d;
  logic             start_tag_q, start_tag_d;
  logic             small_q, small_d;
  logic             tagged_q, tagged_d;
  logic [WIDTH-1:0] int_q, int_d;
  logic [WIDTH-1:0] sint_q, sint_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             type_mode_q, type_mode_d;
  logic             small_seen_q, small_seen_d;

  // ---------------------------------------------------------------------------
  // Length/type field decode (only consumed while len_valid is high)
  // ---------------------------------------------------------------------------
  logic        dec_is_type;
  logic        dec_is_len;
  logic        dec_bad;
  logic [15:0] dec_mindata;
  logic [15:0] dec_eff_len;
  logic        dec_small;
  logic [WIDTH-1:0] dec_int;
  logic [WIDTH-1:0] dec_sint;

  always_comb begin
    dec_is_type = (len_type >= TYPE_MIN);
    dec_is_len  = (len_type <= 16'(MAX_LEN));
    // The gap between the largest legal length and the first type code is
    // neither a length nor a type.
    dec_bad     = !dec_is_type && !dec_is_len;
    dec_mindata = vlan_detect ? 16'(MIN_DATA_TAG) : 16'(MIN_DATA);
    dec_small   = dec_is_len && (len_type < dec_mindata);
    // Short data fields are padded up to the minimum, so the counter must run
    // over the padded size.
    dec_eff_len = dec_small ? dec_mindata : len_type;
    if (dec_is_type) begin
      dec_int  = WIDTH'(TYPE_WORDS);
      dec_sint = WIDTH'(TYPE_WORDS);
    end else begin
      dec_int  = WIDTH'(dec_eff_len >> 3);
      dec_sint = dec_small ? WIDTH'(len_type >> 3) : WIDTH'(dec_eff_len >> 3);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    start_data_d = start_data_q;
    start_tag_d  = start_tag_q;
    small_d      = small_q;
    tagged_d     = tagged_q;
    int_d        = int_q;
    sint_d       = sint_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    type_mode_d  = type_mode_q;
    small_seen_d = small_seen_q;

    unique case (state_q)
      IDLE: begin
        if (sof) begin
          state_d = WAIT_LEN;
        end
      end

      WAIT_LEN: begin
        if (len_valid) begin
          if (dec_bad) begin
            // Unusable field: flag it and let the frame drain in TAIL
            // without ever enabling a counter.
            err_d   = 1'b1;
            state_d = TAIL;
          end else begin
            tagged_d     = vlan_detect;
            small_d      = dec_small;
            int_d        = dec_int;
            sint_d       = dec_sint;
            type_mode_d  = dec_is_type;
            start_tag_d  = vlan_detect;
            start_data_d = !vlan_detect;
            small_seen_d = 1'b0;
            state_d      = COUNT;
          end
        end else if (eof) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      COUNT: begin
        if (end_data_cnt) begin
          // Counter reached the end of the data field. A coincident eof
          // only decides whether there is still a tail to wait for.
          start_data_d = 1'b0;
          start_tag_d  = 1'b0;
          done_d       = 1'b1;
          state_d      = eof ? IDLE : TAIL;
        end else if (eof) begin
          // In type mode the word count is only a ceiling, so an early
          // terminate is a normal end of data. In length mode it means the
          // frame was shorter than its length field claimed.
          start_data_d = 1'b0;
          start_tag_d  = 1'b0;
          done_d       = type_mode_q;
          err_d        = !type_mode_q;
          state_d      = IDLE;
        end else if (end_small_cnt && small_q) begin
          small_seen_d = 1'b1;
        end
      end

      TAIL: begin
        if (sof) begin
          // A new frame started before the previous one terminated.
          err_d   = 1'b1;
          state_d = WAIT_LEN;
        end else if (eof) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything, including the pulses computed above.
    if (abort) begin
      state_d      = IDLE;
      start_data_d = 1'b0;
      start_tag_d  = 1'b0;
      small_d      = 1'b0;
      tagged_d     = 1'b0;
      int_d        = '0;
      sint_d       = '0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      type_mode_d  = 1'b0;
      small_seen_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge rxclk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      start_data_q <= 1'b0;
      start_tag_q  <= 1'b0;
      small_q      <= 1'b0;
      tagged_q     <= 1'b0;
      int_q        <= '0;
      sint_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      type_mode_q  <= 1'b0;
      small_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_data_q <= start_data_d;
      start_tag_q  <= start_tag_d;
      small_q      <= small_d;
      tagged_q     <= tagged_d;
      int_q        <= int_d;
      sint_q       <= sint_d;
      done_q       <= done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      type_mode_q  <= type_mode_d;
      small_seen_q <= small_seen_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign start_data_cnt    = start_data_q;
  assign start_tagged_cnt  = start_tag_q;
  assign small_frame       = small_q;
  assign tagged_frame      = tagged_q;
  assign integer_cnt       = int_q;
  assign small_integer_cnt = sint_q;
  assign data_done         = done_q;
  assign len_err           = err_q;
  assign busy              = busy_q;
  assign dbg_state         = state_q;
  assign small_data_seen   = small_seen_q;

endmodule

// File: tb/tb_rx_len_count_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rx_len_count_ctrl
//
// Drives whole frames (sof, length field, counter strobes, eof/abort) and
// keeps two expected queues: one for the counter configuration that must
// appear when a counter enable rises, one for the data_done / len_err pulses.
// A monitor on the falling clock edge pops and compares whenever the DUT
// presents one of those outputs.
// -----------------------------------------------------------------------------
module tb_rx_len_count_ctrl;

  localparam int W = 13;

  localparam logic [1:0] EV_DONE = 2'd1;
  localparam logic [1:0] EV_ERR  = 2'd2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic rxclk = 1'b0;
  logic reset = 1'b0;
  always #5 rxclk = ~rxclk;

  logic          sof, len_valid, vlan_detect, eof, abort;
  logic          end_data_cnt, end_small_cnt;
  logic [15:0]   len_type;
  logic          start_data_cnt, start_tagged_cnt, small_frame, tagged_frame;
  logic [W-1:0]  integer_cnt, small_integer_cnt;
  logic          data_done, len_err, busy, small_data_seen;
  logic [1:0]    dbg_state;

  rx_len_count_ctrl dut (
    .rxclk             (rxclk),
    .reset             (reset),
    .sof               (sof),
    .len_valid         (len_valid),
    .len_type          (len_type),
    .vlan_detect       (vlan_detect),
    .eof               (eof),
    .abort             (abort),
    .end_data_cnt      (end_data_cnt),
    .end_small_cnt     (end_small_cnt),
    .start_data_cnt    (start_data_cnt),
    .start_tagged_cnt  (start_tagged_cnt),
    .small_frame       (small_frame),
    .tagged_frame      (tagged_frame),
    .integer_cnt       (integer_cnt),
    .small_integer_cnt (small_integer_cnt),
    .data_done         (data_done),
    .len_err           (len_err),
    .busy              (busy),
    .dbg_state         (dbg_state),
    .small_data_seen   (small_data_seen)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [1:0]  exp_q[$];      // expected pulse events
  logic [29:0] exp_cfg_q[$];  // {st_tag, st_data, small, tagged, int, sint}
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counter configuration from the field rules.
  function automatic logic [29:0] model_cfg(input logic [15:0] lt, input logic vl);
    int mind, eff, wi, ws;
    bit sm;
    mind = vl ? 42 : 46;
    if (lt >= 16'h0600) begin
      wi = 188;
      ws = 188;
      sm = 1'b0;
    end else begin
      sm  = (int'(lt) < mind);
      eff = sm ? mind : int'(lt);
      wi  = eff / 8;
      ws  = sm ? int'(lt) / 8 : wi;
    end
    return {vl, !vl, sm, vl, 13'(wi), 13'(ws)};
  endfunction

  function automatic bit is_bad(input logic [15:0] lt);
    return (lt > 16'd1500) && (lt < 16'h0600);
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({start_data_cnt, start_tagged_cnt, small_frame, tagged_frame,
                integer_cnt, small_integer_cnt, data_done, len_err, busy});
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic prev_start = 1'b0;

  always @(negedge rxclk) begin
    if (!reset) begin
      prev_start <= 1'b0;
    end else begin
      check("start_exclusive", 64'(start_data_cnt & start_tagged_cnt), 64'd0);
      if ((start_data_cnt | start_tagged_cnt) && !prev_start) begin
        if (exp_cfg_q.size() == 0) begin
          check("unexpected_start", 64'd1, 64'd0);
        end else begin
          check("counter_cfg",
                64'({start_tagged_cnt, start_data_cnt, small_frame, tagged_frame,
                     integer_cnt, small_integer_cnt}),
                64'(exp_cfg_q.pop_front()));
        end
      end
      prev_start <= start_data_cnt | start_tagged_cnt;
      if (data_done || len_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 64'({data_done, len_err}), 64'd0);
        end else begin
          check("pulse_kind", 64'({len_err, data_done}), 64'(exp_q.pop_front()));
        end
        if (data_done) begin
          check("start_off_at_done", 64'(start_data_cnt | start_tagged_cnt), 64'd0);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge rxclk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic count_wait(input int n);
    for (int i = 0; i < n; i++) begin
      end_small_cnt = 1'($urandom_range(0, 1));
      tick();
    end
    end_small_cnt = 1'b0;
  endtask

  task automatic pulse_sof();
    sof = 1'b1; tick(); sof = 1'b0;
  endtask

  task automatic pulse_eof();
    eof = 1'b1; tick(); eof = 1'b0;
  endtask

  // scen: 0 end_data then eof in tail, 1 eof in count, 2 end+eof together,
  //       3 abort in count, 4 eof before length, 5 sof while in tail
  task automatic run_frame(input logic [15:0] lt, input logic vl, input int scen);
    logic [29:0] cfg;
    pulse_sof();
    tick_n($urandom_range(0, 2));
    if (scen == 4) begin
      exp_q.push_back(EV_ERR);
      pulse_eof();
      tick();
      check("busy_after_frame", 64'(busy), 64'd0);
      return;
    end
    cfg = model_cfg(lt, vl);
    if (is_bad(lt)) begin
      exp_q.push_back(EV_ERR);
    end else begin
      exp_cfg_q.push_back(cfg);
    end
    len_type = lt; vlan_detect = vl; len_valid = 1'b1;
    tick();
    len_valid = 1'b0; len_type = $urandom_range(0, 16'hffff); vlan_detect = 1'b0;
    if (is_bad(lt)) begin
      tick_n($urandom_range(0, 3));
      check("busy_in_tail", 64'(busy), 64'd1);
      pulse_eof();
      tick();
      check("busy_after_frame", 64'(busy), 64'd0);
      return;
    end
    count_wait($urandom_range(0, 4));
    case (scen)
      0: begin
        exp_q.push_back(EV_DONE);
        end_data_cnt = 1'b1; tick(); end_data_cnt = 1'b0;
        tick_n($urandom_range(0, 3));
        check("busy_in_tail", 64'(busy), 64'd1);
        pulse_eof();
      end
      1: begin
        exp_q.push_back((lt >= 16'h0600) ? EV_DONE : EV_ERR);
        pulse_eof();
      end
      2: begin
        exp_q.push_back(EV_DONE);
        end_data_cnt = 1'b1; eof = 1'b1; tick();
        end_data_cnt = 1'b0; eof = 1'b0;
      end
      3: begin
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_outputs", all_outs(), 64'd0);
      end
      default: begin
        exp_q.push_back(EV_DONE);
        end_data_cnt = 1'b1; tick(); end_data_cnt = 1'b0;
        exp_q.push_back(EV_ERR);
        pulse_sof();
        exp_q.push_back(EV_ERR);
        pulse_eof();
      end
    endcase
    tick();
    check("busy_after_frame", 64'(busy), 64'd0);
    if (scen != 3) begin
      check("counts_hold", 64'({small_frame, tagged_frame, integer_cnt, small_integer_cnt}),
            64'(cfg[27:0]));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    sof = 0; len_valid = 0; len_type = 0; vlan_detect = 0; eof = 0;
    abort = 0; end_data_cnt = 0; end_small_cnt = 0;
    reset = 1'b0;
    tick_n(3);
    check("reset_outputs", all_outs(), 64'd0);
    reset = 1'b1;
    tick_n(2);
    check("idle_after_reset", 64'(busy), 64'd0);

    // stray eof/len_valid in IDLE are ignored
    len_valid = 1'b1; len_type = 16'd100; eof = 1'b1; tick();
    len_valid = 1'b0; eof = 1'b0; tick();
    check("idle_ignores_inputs", all_outs(), 64'd0);

    run_frame(16'd100, 1'b0, 0);
    check("l100_int", 64'(integer_cnt), 64'd12);
    check("l100_small", 64'(small_frame), 64'd0);
    run_frame(16'd20, 1'b0, 0);
    check("l20_small", 64'({small_frame, integer_cnt, small_integer_cnt}),
          64'({1'b1, 13'd5, 13'd2}));
    run_frame(16'd30, 1'b1, 0);
    check("l30_tag", 64'({tagged_frame, integer_cnt, small_integer_cnt}),
          64'({1'b1, 13'd5, 13'd3}));
    run_frame(16'h0800, 1'b0, 1);
    check("type_int", 64'(integer_cnt), 64'd188);
    run_frame(16'h0580, 1'b0, 0);
    run_frame(16'd64, 1'b0, 1);
    run_frame(16'd64, 1'b0, 2);
    run_frame(16'd64, 1'b0, 3);
    run_frame(16'd64, 1'b0, 4);
    run_frame(16'd200, 1'b1, 5);
    run_frame(16'd1500, 1'b0, 0);
    run_frame(16'd1501, 1'b1, 0);
    run_frame(16'h05ff, 1'b0, 1);
    run_frame(16'h0600, 1'b1, 1);
    run_frame(16'd46, 1'b0, 0);
    run_frame(16'd45, 1'b0, 0);
    run_frame(16'd42, 1'b1, 2);
    run_frame(16'd41, 1'b1, 2);

    // reset asserted mid-frame clears everything immediately
    exp_cfg_q.push_back(model_cfg(16'd300, 1'b0));
    pulse_sof();
    len_type = 16'd300; len_valid = 1'b1; tick(); len_valid = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1 check("async_reset_outputs", all_outs(), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    for (int n = 0; n < 80; n++) begin
      logic [15:0] lt;
      logic        vl;
      int          cls;
      vl  = 1'($urandom_range(0, 1));
      cls = $urandom_range(0, 3);
      case (cls)
        0:       lt = 16'($urandom_range(0, vl ? 41 : 45));
        1:       lt = 16'($urandom_range(vl ? 42 : 46, 1500));
        2:       lt = 16'($urandom_range(16'h0600, 16'hffff));
        default: lt = 16'($urandom_range(1501, 16'h05ff));
      endcase
      run_frame(lt, vl, $urandom_range(0, 5));
    end

    tick_n(3);
    check("pulse_queue_drained", 64'(exp_q.size()), 64'd0);
    check("cfg_queue_drained", 64'(exp_cfg_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
